// File: rtl/mem_arbiter_rr_pkg.sv
// Shared types and width helpers for the round-robin memory arbiter.

`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 32
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 64
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 4
`endif

package mem_arb_pkg;

    // Request-channel FSM: IDLE arbitrates, WDATA streams one owner's write beats.
    typedef enum logic {
        IDLE  = 1'b0,
        WDATA = 1'b1
    } arb_state_e;

    // Outstanding-read counters hold 0..15, enough for any legal limit.
    localparam int OUTST_CNT_BITS = 4;

    // Width of a port index; a single-port arbiter still gets one bit.
    function automatic int port_bits(input int num_ports);
        return (num_ports <= 1) ? 1 : $clog2(num_ports);
    endfunction

    // Width of a beat counter that runs 0..beats-1.
    function automatic int beat_cnt_bits(input int beats);
        return (beats <= 1) ? 1 : $clog2(beats);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_rr_pick.sv
// Combinational round-robin picker: first eligible port at or after ptr_i wins.

module rr_pick #(
    parameter int NUM_PORTS = 2,
    parameter int PORT_BITS = 1
) (
    input  logic [NUM_PORTS-1:0] eligible_i,
    input  logic [PORT_BITS-1:0] ptr_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output logic [PORT_BITS-1:0] idx_o,
    output logic                 any_o
);

    logic found;

    // Scan ports in rotated order starting at the pointer; keep the first hit.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        for (int off = 0; off < NUM_PORTS; off++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (!found && eligible_i[p] &&
                    (p == ((int'(ptr_i) + off >= NUM_PORTS) ? int'(ptr_i) + off - NUM_PORTS
                                                            : int'(ptr_i) + off))) begin
                    found      = 1'b1;
                    grant_o[p] = 1'b1;
                    idx_o      = PORT_BITS'(p);
                end
            end
        end
        any_o = |eligible_i;
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-port round-robin arbiter in front of a single main-memory interface.
// Handshakes: a transfer happens on a channel in a cycle where its valid and
// ready are both high; valid never depends on ready of the same channel, the
// response channel has no ready and every mem_resp_valid beat is consumed.

module mem_arbiter_rr
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS       = 2,
    parameter int ADDR_BITS       = `MEM_ADDR_BITS,
    parameter int DATA_BITS       = `MEM_DATA_BITS,
    parameter int TAG_BITS        = `MEM_TAG_BITS,
    parameter int DATA_BEATS      = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_PORTS-1:0]             req_valid,
    output logic [NUM_PORTS-1:0]             req_ready,
    input  logic [NUM_PORTS-1:0]             req_rw,
    input  logic [NUM_PORTS*ADDR_BITS-1:0]   req_addr,
    input  logic [NUM_PORTS-1:0]             wdata_valid,
    output logic [NUM_PORTS-1:0]             wdata_ready,
    input  logic [NUM_PORTS*DATA_BITS-1:0]   wdata_bits,
    input  logic [NUM_PORTS*DATA_BITS/8-1:0] wdata_mask,
    output logic [NUM_PORTS-1:0]             resp_valid,
    output logic [NUM_PORTS-1:0]             resp_last,
    output logic [DATA_BITS-1:0]             resp_data,
    output logic                             mem_req_valid,
    input  logic                             mem_req_ready,
    output logic                             mem_req_rw,
    output logic [ADDR_BITS-1:0]             mem_req_addr,
    output logic [TAG_BITS-1:0]              mem_req_tag,
    output logic                             mem_req_data_valid,
    input  logic                             mem_req_data_ready,
    output logic [DATA_BITS-1:0]             mem_req_data_bits,
    output logic [DATA_BITS/8-1:0]           mem_req_data_mask,
    input  logic                             mem_resp_valid,
    input  logic [DATA_BITS-1:0]             mem_resp_data,
    input  logic [TAG_BITS-1:0]              mem_resp_tag,
    output logic                             err_bad_tag
);

    localparam int PORT_BITS = port_bits(NUM_PORTS);
    localparam int BEAT_BITS = beat_cnt_bits(DATA_BEATS);
    localparam int MASK_BITS = DATA_BITS / 8;
    localparam logic [BEAT_BITS-1:0]      LAST_BEAT = BEAT_BITS'(DATA_BEATS - 1);
    localparam logic [OUTST_CNT_BITS-1:0] RD_LIMIT  = OUTST_CNT_BITS'(MAX_OUTSTANDING);
    localparam logic [PORT_BITS-1:0]      LAST_PORT = PORT_BITS'(NUM_PORTS - 1);

    arb_state_e                state_q, state_d;
    logic [PORT_BITS-1:0]      rr_ptr_q, rr_ptr_d;
    logic [PORT_BITS-1:0]      owner_q, owner_d;
    logic [BEAT_BITS-1:0]      beat_cnt_q, beat_cnt_d;
    logic [BEAT_BITS-1:0]      rsp_beat_q, rsp_beat_d;
    logic                      err_q, err_d;
    logic [OUTST_CNT_BITS-1:0] rd_cnt_q [NUM_PORTS];
    logic [OUTST_CNT_BITS-1:0] rd_cnt_d [NUM_PORTS];

    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] pick_grant;
    logic [PORT_BITS-1:0] pick_idx;
    logic                 pick_any;
    logic [NUM_PORTS-1:0] rd_issue;
    logic [NUM_PORTS-1:0] rd_ret;
    logic [PORT_BITS-1:0] resp_port;
    logic                 resp_port_ok;

    // Writes are always eligible; reads only while below the in-flight limit.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            eligible[i] = req_valid[i] & (req_rw[i] | (rd_cnt_q[i] < RD_LIMIT));
        end
    end

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_BITS (PORT_BITS)
    ) u_pick (
        .eligible_i (eligible),
        .ptr_i      (rr_ptr_q),
        .grant_o    (pick_grant),
        .idx_o      (pick_idx),
        .any_o      (pick_any)
    );

    // Request/write-data FSM: arbitrate in IDLE, forward owner's beats in WDATA.
    always_comb begin
        state_d            = state_q;
        rr_ptr_d           = rr_ptr_q;
        owner_d            = owner_q;
        beat_cnt_d         = beat_cnt_q;
        req_ready          = '0;
        wdata_ready        = '0;
        rd_issue           = '0;
        mem_req_valid      = 1'b0;
        mem_req_rw         = req_rw[pick_idx];
        mem_req_addr       = req_addr[int'(pick_idx)*ADDR_BITS +: ADDR_BITS];
        mem_req_tag        = TAG_BITS'(pick_idx);
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = wdata_bits[int'(owner_q)*DATA_BITS +: DATA_BITS];
        mem_req_data_mask  = wdata_mask[int'(owner_q)*MASK_BITS +: MASK_BITS];
        case (state_q)
            IDLE: begin
                mem_req_valid = reset_n & pick_any;
                if (mem_req_valid && mem_req_ready) begin
                    req_ready = pick_grant;
                    rr_ptr_d  = (pick_idx == LAST_PORT) ? '0 : pick_idx + 1'b1;
                    if (mem_req_rw) begin
                        owner_d    = pick_idx;
                        beat_cnt_d = '0;
                        state_d    = WDATA;
                    end else begin
                        rd_issue = pick_grant;
                    end
                end
            end
            WDATA: begin
                mem_req_data_valid   = reset_n & wdata_valid[owner_q];
                wdata_ready[owner_q] = reset_n & mem_req_data_ready;
                if (mem_req_data_valid && mem_req_data_ready) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response routing by tag; bad tags are flagged but still count as beats.
    always_comb begin
        resp_port    = (NUM_PORTS > 1) ? mem_resp_tag[PORT_BITS-1:0] : '0;
        resp_port_ok = int'(resp_port) < NUM_PORTS;
        resp_data    = mem_resp_data;
        resp_valid   = '0;
        resp_last    = '0;
        rd_ret       = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (reset_n && mem_resp_valid && resp_port_ok && (int'(resp_port) == i)) begin
                resp_valid[i] = 1'b1;
                resp_last[i]  = (rsp_beat_q == LAST_BEAT);
                rd_ret[i]     = (rsp_beat_q == LAST_BEAT);
            end
        end
        rsp_beat_d = rsp_beat_q;
        if (mem_resp_valid) begin
            rsp_beat_d = (rsp_beat_q == LAST_BEAT) ? '0 : rsp_beat_q + 1'b1;
        end
        err_d = err_q | (mem_resp_valid & ~resp_port_ok);
    end

    // Outstanding-read bookkeeping; a same-cycle issue and return cancel out.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            rd_cnt_d[i] = rd_cnt_q[i];
            if (rd_issue[i] && !rd_ret[i]) begin
                rd_cnt_d[i] = rd_cnt_q[i] + 1'b1;
            end else if (!rd_issue[i] && rd_ret[i] && (rd_cnt_q[i] != '0)) begin
                rd_cnt_d[i] = rd_cnt_q[i] - 1'b1;
            end
        end
    end

    // State registers; reset drops everything immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
            rsp_beat_q <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                rd_cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            rsp_beat_q <= rsp_beat_d;
            err_q      <= err_d;
            for (int i = 0; i < NUM_PORTS; i++) begin
                rd_cnt_q[i] <= rd_cnt_d[i];
            end
        end
    end

    assign err_bad_tag = err_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr with three ports and four-beat lines.

module tb_mem_arbiter_rr;

    localparam int NP = 3;
    localparam int AB = 16;
    localparam int DB = 32;
    localparam int TB = 4;
    localparam int BEATS = 4;
    localparam int MO = 4;
    localparam int MB = DB / 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NP-1:0]    req_valid;
    logic [NP-1:0]    req_ready;
    logic [NP-1:0]    req_rw;
    logic [NP*AB-1:0] req_addr;
    logic [NP-1:0]    wdata_valid;
    logic [NP-1:0]    wdata_ready;
    logic [NP*DB-1:0] wdata_bits;
    logic [NP*MB-1:0] wdata_mask;
    logic [NP-1:0]    resp_valid;
    logic [NP-1:0]    resp_last;
    logic [DB-1:0]    resp_data;
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic             mem_req_rw;
    logic [AB-1:0]    mem_req_addr;
    logic [TB-1:0]    mem_req_tag;
    logic             mem_req_data_valid;
    logic             mem_req_data_ready;
    logic [DB-1:0]    mem_req_data_bits;
    logic [MB-1:0]    mem_req_data_mask;
    logic             mem_resp_valid;
    logic [DB-1:0]    mem_resp_data;
    logic [TB-1:0]    mem_resp_tag;
    logic             err_bad_tag;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_arbiter_rr #(
        .NUM_PORTS       (NP),
        .ADDR_BITS       (AB),
        .DATA_BITS       (DB),
        .TAG_BITS        (TB),
        .DATA_BEATS      (BEATS),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_rw             (req_rw),
        .req_addr           (req_addr),
        .wdata_valid        (wdata_valid),
        .wdata_ready        (wdata_ready),
        .wdata_bits         (wdata_bits),
        .wdata_mask         (wdata_mask),
        .resp_valid         (resp_valid),
        .resp_last          (resp_last),
        .resp_data          (resp_data),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_rw         (mem_req_rw),
        .mem_req_addr       (mem_req_addr),
        .mem_req_tag        (mem_req_tag),
        .mem_req_data_valid (mem_req_data_valid),
        .mem_req_data_ready (mem_req_data_ready),
        .mem_req_data_bits  (mem_req_data_bits),
        .mem_req_data_mask  (mem_req_data_mask),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_data      (mem_resp_data),
        .mem_resp_tag       (mem_resp_tag),
        .err_bad_tag        (err_bad_tag)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // One full response line on the given tag, no checks.
    task automatic send_resp(input logic [TB-1:0] tag);
        for (int b = 0; b < BEATS; b++) begin
            mem_resp_valid = 1'b1;
            mem_resp_tag   = tag;
            mem_resp_data  = 32'hC000_0000 + b;
            adv();
        end
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b;
        logic r;

        // Reset held with live inputs: every valid/ready output must stay low.
        reset_n            = 1'b0;
        req_valid          = 3'b011;
        req_rw             = 3'b000;
        req_addr           = {16'h0300, 16'h0200, 16'h0100};
        wdata_valid        = 3'b000;
        wdata_bits         = '0;
        wdata_mask         = '0;
        mem_req_ready      = 1'b1;
        mem_req_data_ready = 1'b1;
        mem_resp_valid     = 1'b1;
        mem_resp_data      = 32'h0;
        mem_resp_tag       = 4'd1;
        settle();
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_data_valid", mem_req_data_valid, 0);
        chk("rst_err", err_bad_tag, 0);
        adv();
        adv();
        reset_n        = 1'b1;
        mem_resp_valid = 1'b0;

        // Two readers every cycle: grants and tags alternate 0,1,0,1.
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("alt_tag", mem_req_tag, k % 2);
            chk("alt_ready", req_ready, (k % 2 == 0) ? 3'b001 : 3'b010);
            chk("alt_addr", mem_req_addr, (k % 2 == 0) ? 16'h0100 : 16'h0200);
            chk("alt_rw", mem_req_rw, 0);
            adv();
        end
        req_valid = 3'b000;

        // Tag-1 line: port 1 sees all four beats, last only on the fourth.
        for (int k = 0; k < BEATS; k++) begin
            mem_resp_valid = 1'b1;
            mem_resp_tag   = 4'd1;
            mem_resp_data  = 32'hD100_0000 + k;
            settle();
            chk("rsp1_valid", resp_valid, 3'b010);
            chk("rsp1_last", resp_last, (k == BEATS - 1) ? 3'b010 : 3'b000);
            chk("rsp1_data", resp_data, 32'hD100_0000 + k);
            adv();
        end
        mem_resp_valid = 1'b0;
        send_resp(4'd1);
        send_resp(4'd0);
        send_resp(4'd0);

        // Port 0 write with data ready toggling; port 1 read waits behind it.
        req_valid  = 3'b011;
        req_rw     = 3'b001;
        wdata_mask = {4'h0, 4'hA, 4'h5};
        settle();
        chk("wr_addr_valid", mem_req_valid, 1);
        chk("wr_addr_rw", mem_req_rw, 1);
        chk("wr_addr_ready", req_ready, 3'b001);
        chk("wr_addr_tag", mem_req_tag, 0);
        adv();
        wdata_valid = 3'b011;
        b = 0;
        for (int k = 0; k < 7; k++) begin
            r = (k % 2 == 0);
            mem_req_data_ready = r;
            wdata_bits = {32'h0, 32'hB000_0000, 32'hA000_0000 + b};
            settle();
            chk("wd_req_blocked", mem_req_valid, 0);
            chk("wd_req_ready", req_ready, 0);
            chk("wd_ready", wdata_ready, {2'b00, r});
            chk("wd_valid", mem_req_data_valid, 1);
            chk("wd_bits", mem_req_data_bits, 32'hA000_0000 + b);
            chk("wd_mask", mem_req_data_mask, 4'h5);
            adv();
            if (r) b++;
        end
        wdata_valid        = 3'b000;
        mem_req_data_ready = 1'b1;
        settle();
        chk("rd_after_wr_ready", req_ready, 3'b010);
        chk("rd_after_wr_tag", mem_req_tag, 1);
        chk("rd_after_wr_rw", mem_req_rw, 0);
        adv();

        // Port 1 fills its in-flight limit; port 0 still gets through.
        req_valid = 3'b010;
        req_rw    = 3'b000;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("fill_p1", req_ready, 3'b010);
            adv();
        end
        settle();
        chk("limit_block_valid", mem_req_valid, 0);
        chk("limit_block_ready", req_ready, 0);
        adv();
        req_valid = 3'b011;
        settle();
        chk("p0_passes_ready", req_ready, 3'b001);
        chk("p0_passes_tag", mem_req_tag, 0);
        adv();
        req_valid = 3'b010;
        for (int k = 0; k < BEATS; k++) begin
            mem_resp_valid = 1'b1;
            mem_resp_tag   = 4'd1;
            mem_resp_data  = 32'hE000_0000 + k;
            settle();
            chk("limit_hold", mem_req_valid, 0);
            adv();
        end
        mem_resp_valid = 1'b0;
        settle();
        chk("limit_release", req_ready, 3'b010);
        adv();
        req_valid = 3'b000;

        // Port 0 (one read in flight) issues a read on its own last response beat.
        for (int k = 0; k < BEATS; k++) begin
            mem_resp_valid = 1'b1;
            mem_resp_tag   = 4'd0;
            mem_resp_data  = 32'hF000_0000 + k;
            if (k == BEATS - 1) req_valid = 3'b001;
            settle();
            if (k == BEATS - 1) begin
                chk("same_cycle_issue", req_ready, 3'b001);
                chk("same_cycle_last", resp_last, 3'b001);
            end
            adv();
        end
        mem_resp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("refill_p0", req_ready, 3'b001);
            adv();
        end
        settle();
        chk("refill_block", mem_req_valid, 0);
        adv();
        req_valid = 3'b000;

        // Tag 3 decodes to a port that does not exist.
        for (int k = 0; k < BEATS; k++) begin
            mem_resp_valid = 1'b1;
            mem_resp_tag   = 4'd3;
            mem_resp_data  = 32'h3300_0000 + k;
            settle();
            chk("bad_tag_rv", resp_valid, 0);
            chk("bad_tag_rl", resp_last, 0);
            if (k > 0) chk("bad_tag_err", err_bad_tag, 1);
            adv();
        end
        mem_resp_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("err_held", err_bad_tag, 1);
            adv();
        end
        for (int k = 0; k < BEATS; k++) begin
            mem_resp_valid = 1'b1;
            mem_resp_tag   = 4'd1;
            mem_resp_data  = 32'h1100_0000 + k;
            settle();
            chk("after_bad_valid", resp_valid, 3'b010);
            chk("after_bad_last", resp_last, (k == BEATS - 1) ? 3'b010 : 3'b000);
            adv();
        end
        mem_resp_valid = 1'b0;

        // Reset pulsed during the second write beat.
        req_valid = 3'b001;
        req_rw    = 3'b001;
        settle();
        chk("wr2_addr", req_ready, 3'b001);
        adv();
        req_valid   = 3'b000;
        wdata_valid = 3'b001;
        wdata_bits  = {32'h0, 32'h0, 32'h5555_0000};
        settle();
        chk("wr2_beat1", wdata_ready, 3'b001);
        adv();
        reset_n        = 1'b0;
        req_valid      = 3'b011;
        mem_resp_valid = 1'b1;
        mem_resp_tag   = 4'd1;
        settle();
        chk("rst_mid_data_valid", mem_req_data_valid, 0);
        chk("rst_mid_wdata_ready", wdata_ready, 0);
        chk("rst_mid_req_valid", mem_req_valid, 0);
        chk("rst_mid_req_ready", req_ready, 0);
        chk("rst_mid_resp_valid", resp_valid, 0);
        chk("rst_mid_err", err_bad_tag, 0);
        adv();
        reset_n        = 1'b1;
        req_rw         = 3'b000;
        mem_resp_valid = 1'b0;
        wdata_valid    = 3'b000;
        settle();
        chk("post_rst_ready", req_ready, 3'b001);
        chk("post_rst_tag", mem_req_tag, 0);
        chk("post_rst_rw", mem_req_rw, 0);
        adv();
        req_valid = 3'b000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_rr.md
# mem_arbiter_rr

Parametrised N-port round-robin arbiter between the per-core cache instances (icache, dcache, and any further requesters) and the single external main-memory interface. It supports read and write requests, multi-beat write data forwarding and tag-based routing of multi-beat read responses. It also enforces a per-port outstanding-read limit.

## Interface
Parameters:
- NUM_PORTS, 2, number of requesters (1..8)
- ADDR_BITS, `MEM_ADDR_BITS, request address width
- DATA_BITS, `MEM_DATA_BITS, beat width
- TAG_BITS, `MEM_TAG_BITS, memory tag width (≥ clog2(NUM_PORTS))
- DATA_BEATS, 4, beats per line (write data and read response)
- MAX_OUTSTANDING, 4, per-port in-flight read limit (1..15)

Ports (vectors are flattened; port i occupies slice i):
- clk  in  1  single clock; one clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_PORTS  request valid per port
- req_ready  out  NUM_PORTS  request accepted this cycle
- req_rw  in  NUM_PORTS  1 = write, 0 = read
- req_addr  in  NUM_PORTS*ADDR_BITS  line address
- wdata_valid  in  NUM_PORTS  write beat valid
- wdata_ready  out  NUM_PORTS  write beat accepted
- wdata_bits  in  NUM_PORTS*DATA_BITS  write beat data
- wdata_mask  in  NUM_PORTS*DATA_BITS/8  byte mask
- resp_valid  out  NUM_PORTS  read response beat for port i
- resp_last  out  NUM_PORTS  final beat of that response
- resp_data  out  DATA_BITS  shared response data (mem_resp_data passthrough)
- mem_req_valid / mem_req_ready / mem_req_rw / mem_req_addr / mem_req_tag  out/in/out/out/out  1/1/1/ADDR_BITS/TAG_BITS  memory request channel
- mem_req_data_valid / mem_req_data_ready / mem_req_data_bits / mem_req_data_mask  out/in/out/out  1/1/DATA_BITS/DATA_BITS/8  write data channel
- mem_resp_valid / mem_resp_data / mem_resp_tag  in  1/DATA_BITS/TAG_BITS  response channel (no backpressure)
- err_bad_tag  out  1  sticky; response tag decoded to port ≥ NUM_PORTS

## Operation
- States: IDLE, WDATA.
- IDLE:
  - Port i is eligible when req_valid[i] and (req_rw[i] or rd_cnt[i] < MAX_OUTSTANDING).
  - Round-robin pick starts at rr_ptr. mem_req_valid = any eligible; rw and addr are muxed from the winner.
  - mem_req_tag = port index in low bits, zero above.
- Handshake (mem_req_valid & mem_req_ready): req_ready[winner] = 1 and rr_ptr ← winner+1 mod NUM_PORTS.
  - Read: rd_cnt[winner]++.
  - Write: owner ← winner, beat_cnt ← 0, go to WDATA.
- WDATA:
  - mem_req_valid = 0.
  - mem_req_data_valid = wdata_valid[owner]; wdata_ready[owner] = mem_req_data_ready. Bits and mask come from owner.
  - beat_cnt++ per data handshake. After the DATA_BEATS-th handshake, return to IDLE.
  - wdata_ready is 0 for all non-owner ports.
- Responses:
  - Port = mem_resp_tag[clog2(NUM_PORTS)-1:0]. resp_valid[port] = mem_resp_valid.
  - A global rsp_beat counter counts beats. resp_last asserts when rsp_beat == DATA_BEATS-1; rsp_beat then wraps to 0 and rd_cnt[port]--.
  - Beats of one response are contiguous; responses return in memory order.
- Same-cycle read issue and last response beat on the same port: rd_cnt unchanged.
- Decoded port ≥ NUM_PORTS: no resp_valid asserted, err_bad_tag set until reset. rsp_beat still advances.

## Timing
- Request path is combinational (req_valid → mem_req_valid, mem_req_ready → req_ready): zero added latency. Response path is combinational (mem_resp_* → resp_*).
- Reset values: state IDLE, rr_ptr 0, rd_cnt 0, beat_cnt 0, rsp_beat 0, err_bad_tag 0. All ready/valid outputs are 0 while reset_n is low.
- A write blocks the request channel from the address handshake until the last data beat: at minimum 1 + DATA_BEATS cycles.
- Reset asserted mid-write or mid-response drops all state immediately. In-flight memory responses after reset are the system's responsibility.
- Requesters must hold req_* stable until req_ready. The grant may change between cycles while unaccepted.

## Structure
- Package mem_arb_pkg: state enum (IDLE, WDATA), clog2-derived PORT_BITS helper, beat/outstanding counter width localparams.
- Sub-module rr_pick: combinational NUM_PORTS-wide round-robin priority picker (eligible mask, pointer → one-hot grant + index).

## Test plan
- NUM_PORTS=2, both ports request reads every cycle with mem_req_ready=1 → grants alternate 0,1,0,1; tags 0,1,0,1.
- Port 0 write, DATA_BEATS=4, mem_req_data_ready toggling 1,0,1,0… → 4 beats forwarded in 7 cycles. Port 1 read is held off until the cycle after the 4th beat.
- Port 1 issues 4 reads with no responses (MAX_OUTSTANDING=4) → 5th read is not accepted. Port 0 is still granted. After 4 beats with tag 1, port 1 is accepted again.
- Response with tag 1 for 4 beats → resp_valid[1] on all 4 beats, resp_last[1] on beat 4 only, resp_valid[0] stays 0.
- NUM_PORTS=3, response tag 3 → no resp_valid, err_bad_tag=1 and held.
- reset_n pulsed low during WDATA beat 2 → state IDLE, rr_ptr 0, all outputs 0. A new read is accepted in the first cycle after reset release.
